// File: rtl/ndma_pkg.sv
// Shared types and register map for the ndma descriptor queue.
package ndma_pkg;

  localparam int MAX_TX_SIZE = 256;
  localparam int LEN_W       = $clog2(MAX_TX_SIZE);

  // Word index of each register, i.e. byte offset [4:2]
  localparam logic [2:0] OFS_SRC      = 3'd0;
  localparam logic [2:0] OFS_DST      = 3'd1;
  localparam logic [2:0] OFS_LEN      = 3'd2;
  localparam logic [2:0] OFS_PUSH     = 3'd3;
  localparam logic [2:0] OFS_STATUS   = 3'd4;
  localparam logic [2:0] OFS_DONE_CNT = 3'd5;
  localparam logic [2:0] OFS_CTRL     = 3'd6;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    RUN,
    RETIRE
  } state_t;

  typedef struct packed {
    logic [31:0]      src;
    logic [31:0]      dst;
    logic [LEN_W-1:0] len;
  } desc_t;

  localparam int DESC_W = $bits(desc_t);

endpackage

// File: rtl/ndma_desc_fifo.sv
// Descriptor FIFO with single-cycle flush; flush overrides push and pop.
module ndma_desc_fifo
  import ndma_pkg::*;
#(
  parameter int Depth = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  desc_t                      wdata,
  input  logic                       pop,
  input  logic                       flush,
  output desc_t                      rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(Depth+1)-1:0] usage
);

  localparam int PtrW = $clog2(Depth);
  localparam int UseW = $clog2(Depth + 1);

  desc_t           mem [Depth];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [UseW-1:0] count;
  logic            do_push;
  logic            do_pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  assign full    = (count == UseW'(Depth));
  assign empty   = (count == '0);
  assign usage   = count;
  assign rdata   = mem[rd_ptr];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + UseW'(1);
        2'b01:   count <= count - UseW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ndma_desc_queue.sv
// Descriptor queue and launcher: config registers, descriptor FIFO, launch FSM,
// completion counter and interrupt for the ndma core.
module ndma_desc_queue
  import ndma_pkg::*;
#(
  parameter int Depth     = 4,
  parameter int MaxTxSize = 256,
  parameter int CntWidth  = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         cfg_req_i,
  input  logic                         cfg_we_i,
  output logic                         cfg_gnt_o,
  input  logic [31:0]                  cfg_addr_i,
  input  logic [31:0]                  cfg_wdata_i,
  output logic [31:0]                  cfg_rdata_o,
  output logic                         cfg_rvalid_o,
  output logic [31:0]                  dma_src_addr_o,
  output logic [31:0]                  dma_dst_addr_o,
  output logic [$clog2(MaxTxSize)-1:0] dma_len_o,
  output logic                         dma_start_o,
  input  logic                         dma_done_i,
  output logic                         irq_o
);

  localparam int TxCntBits = $clog2(MaxTxSize);
  localparam int OccW      = $clog2(Depth + 1);

  state_t               state;
  state_t               state_nxt;
  logic                 done_q;
  logic [31:0]          staged_src;
  logic [31:0]          staged_dst;
  logic [TxCntBits-1:0] staged_len;
  logic                 enable;
  logic                 irq_en;
  logic                 overflow;
  logic                 len_err;
  logic                 irq;
  logic [CntWidth-1:0]  done_cnt;
  logic [31:0]          src_act;
  logic [31:0]          dst_act;
  logic [TxCntBits-1:0] len_act;
  logic                 start;
  logic                 rsp_vld_p1;
  logic [31:0]          rsp_data_p1;

  logic [2:0]           idx;
  logic                 acc_wr;
  logic                 acc_rd;
  logic                 push_req;
  logic                 cnt_clr;
  logic                 flush;
  logic                 push;
  logic                 pop;
  logic [31:0]          rd_mux;
  desc_t                push_desc;
  desc_t                head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [OccW-1:0]      occupancy;
  logic                 unused_addr;

  function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
    return (&v) ? v : v + CntWidth'(1);
  endfunction

  assign cfg_gnt_o   = cfg_req_i;
  assign idx         = cfg_addr_i[4:2];
  assign unused_addr = ^{cfg_addr_i[31:5], cfg_addr_i[1:0]};
  assign acc_wr      = cfg_req_i && cfg_we_i;
  assign acc_rd      = cfg_req_i && !cfg_we_i;
  assign push_req    = acc_wr && (idx == OFS_PUSH);
  assign cnt_clr     = acc_wr && (idx == OFS_DONE_CNT);
  assign flush       = acc_wr && (idx == OFS_CTRL) && cfg_wdata_i[2];

  // Fullness is judged before any same-cycle pop, so a pop never makes room for a push
  assign push      = push_req && (staged_len != '0) && !fifo_full;
  assign pop       = (state == IDLE) && enable && !fifo_empty;
  assign push_desc = '{src: staged_src, dst: staged_dst, len: staged_len};

  ndma_desc_fifo #(
    .Depth(Depth)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .wdata (push_desc),
    .pop   (pop),
    .flush (flush),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .usage (occupancy)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // done_q tracks the previous level, so a level left high by the last transfer is not an edge
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable && !fifo_empty) state_nxt = LAUNCH;
      LAUNCH:  state_nxt = RUN;
      RUN:     if (dma_done_i && !done_q) state_nxt = RETIRE;
      RETIRE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (idx)
      OFS_SRC: rd_mux = staged_src;
      OFS_DST: rd_mux = staged_dst;
      OFS_LEN: rd_mux[TxCntBits-1:0] = staged_len;
      OFS_STATUS: begin
        rd_mux[0]         = (state != IDLE);
        rd_mux[1]         = fifo_full;
        rd_mux[2]         = fifo_empty;
        rd_mux[3]         = overflow;
        rd_mux[4]         = len_err;
        rd_mux[8 +: OccW] = occupancy;
      end
      OFS_DONE_CNT: rd_mux[CntWidth-1:0] = done_cnt;
      OFS_CTRL: begin
        rd_mux[0] = enable;
        rd_mux[1] = irq_en;
      end
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      done_q      <= 1'b0;
      staged_src  <= '0;
      staged_dst  <= '0;
      staged_len  <= '0;
      enable      <= 1'b0;
      irq_en      <= 1'b0;
      overflow    <= 1'b0;
      len_err     <= 1'b0;
      irq         <= 1'b0;
      done_cnt    <= '0;
      src_act     <= '0;
      dst_act     <= '0;
      len_act     <= '0;
      start       <= 1'b0;
      rsp_vld_p1  <= 1'b0;
      rsp_data_p1 <= '0;
    end else begin
      done_q <= dma_done_i;
      if (acc_wr) begin
        case (idx)
          OFS_SRC: staged_src <= cfg_wdata_i;
          OFS_DST: staged_dst <= cfg_wdata_i;
          OFS_LEN: staged_len <= cfg_wdata_i[TxCntBits-1:0];
          OFS_CTRL: begin
            enable <= cfg_wdata_i[0];
            irq_en <= cfg_wdata_i[1];
          end
          default: ;
        endcase
      end
      if (cnt_clr) begin
        overflow <= 1'b0;
        len_err  <= 1'b0;
      end
      if (push_req) begin
        if (staged_len == '0) len_err  <= 1'b1;
        else if (fifo_full)   overflow <= 1'b1;
      end
      if (pop) begin
        src_act <= head.src;
        dst_act <= head.dst;
        len_act <= head.len;
      end
      start <= pop;
      // A retire in the same cycle as a clear still counts: set wins
      if (state == RETIRE) done_cnt <= cnt_clr ? CntWidth'(1) : sat_inc(done_cnt);
      else if (cnt_clr)    done_cnt <= '0;
      if (state == RETIRE && irq_en) irq <= 1'b1;
      else if (cnt_clr)              irq <= 1'b0;
      // response stage
      rsp_vld_p1  <= cfg_req_i;
      rsp_data_p1 <= acc_rd ? rd_mux : '0;
    end
  end

  assign dma_src_addr_o = src_act;
  assign dma_dst_addr_o = dst_act;
  assign dma_len_o      = len_act;
  assign dma_start_o    = start;
  assign irq_o          = irq;
  assign cfg_rvalid_o   = rsp_vld_p1;
  assign cfg_rdata_o    = rsp_data_p1;

endmodule

// File: tb/tb_ndma_desc_queue.sv
// Bench for ndma_desc_queue: directed scenarios plus randomized traffic checked
// every cycle against a transaction-level model of the queue.
module tb_ndma_desc_queue;

  localparam int DEPTH  = 4;
  localparam int CNT_W  = 4;
  localparam int CNT_MX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [31:0] src;
    logic [31:0] dst;
    logic [7:0]  len;
  } d_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_req;
  logic        cfg_we;
  logic        cfg_gnt;
  logic [31:0] cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        cfg_rvalid;
  logic [31:0] dma_src;
  logic [31:0] dma_dst;
  logic [7:0]  dma_len;
  logic        dma_start;
  logic        dma_done;
  logic        irq;

  int checks = 0;
  int errors = 0;

  ndma_desc_queue #(
    .Depth(DEPTH),
    .MaxTxSize(256),
    .CntWidth(CNT_W)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cfg_req_i     (cfg_req),
    .cfg_we_i      (cfg_we),
    .cfg_gnt_o     (cfg_gnt),
    .cfg_addr_i    (cfg_addr),
    .cfg_wdata_i   (cfg_wdata),
    .cfg_rdata_o   (cfg_rdata),
    .cfg_rvalid_o  (cfg_rvalid),
    .dma_src_addr_o(dma_src),
    .dma_dst_addr_o(dma_dst),
    .dma_len_o     (dma_len),
    .dma_start_o   (dma_start),
    .dma_done_i    (dma_done),
    .irq_o         (irq)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  d_t          q[$];
  logic [31:0] m_src = 0, m_dst = 0;
  logic [7:0]  m_len = 0;
  logic        m_en = 0, m_irqen = 0, m_ovf = 0, m_lenerr = 0, m_irq = 0;
  logic [CNT_W-1:0] m_cnt = 0;
  logic [31:0] m_asrc = 0, m_adst = 0;
  logic [7:0]  m_alen = 0;
  logic        m_busy = 0, m_start = 0, m_retire = 0, m_done_prev = 0;
  logic        m_rvalid = 0;
  logic [31:0] m_rdata = 0;

  task automatic model_step();
    logic [2:0]       idx;
    logic             wr, rd, full_pre, pop, retire_n, busy_n, irq_n, clr;
    logic [31:0]      rv;
    logic [CNT_W-1:0] cnt_n;
    d_t               head;
    if (rst) begin
      q.delete();
      m_src = 0; m_dst = 0; m_len = 0; m_en = 0; m_irqen = 0; m_ovf = 0; m_lenerr = 0;
      m_irq = 0; m_cnt = 0; m_asrc = 0; m_adst = 0; m_alen = 0; m_busy = 0; m_start = 0;
      m_retire = 0; m_done_prev = 0; m_rvalid = 0; m_rdata = 0;
      return;
    end
    idx = cfg_addr[4:2];
    wr  = cfg_req && cfg_we;
    rd  = cfg_req && !cfg_we;
    clr = wr && idx == 3'd5;
    case (idx)
      3'd0: rv = m_src;
      3'd1: rv = m_dst;
      3'd2: rv = {24'b0, m_len};
      3'd4: rv = {16'b0, 8'(q.size()), 3'b0, m_lenerr, m_ovf, q.size() == 0, q.size() == DEPTH, m_busy};
      3'd5: rv = {{(32-CNT_W){1'b0}}, m_cnt};
      3'd6: rv = {30'b0, m_irqen, m_en};
      default: rv = 0;
    endcase
    full_pre = (q.size() == DEPTH);
    // a transfer is "running" once launched and until its done edge is seen
    retire_n = m_busy && !m_start && !m_retire && dma_done && !m_done_prev;
    pop      = !m_busy && m_en && q.size() != 0;
    busy_n   = m_retire ? 1'b0 : m_busy;
    if (pop) busy_n = 1'b1;
    cnt_n = m_cnt;
    irq_n = m_irq;
    if (clr) begin
      cnt_n = 0; irq_n = 0; m_ovf = 0; m_lenerr = 0;
    end
    if (m_retire) begin
      cnt_n = clr ? 1 : ((m_cnt == CNT_MX) ? m_cnt : m_cnt + 1);
      if (m_irqen) irq_n = 1;
    end
    if (pop) begin
      head = q.pop_front();
      m_asrc = head.src; m_adst = head.dst; m_alen = head.len;
    end
    if (wr && idx == 3'd3) begin
      if (m_len == 0)    m_lenerr = 1;
      else if (full_pre) m_ovf = 1;
      else               q.push_back('{src: m_src, dst: m_dst, len: m_len});
    end
    if (wr && idx == 3'd6 && cfg_wdata[2]) q.delete();
    if (wr) begin
      case (idx)
        3'd0: m_src = cfg_wdata;
        3'd1: m_dst = cfg_wdata;
        3'd2: m_len = cfg_wdata[7:0];
        3'd6: begin m_en = cfg_wdata[0]; m_irqen = cfg_wdata[1]; end
        default: ;
      endcase
    end
    m_done_prev = dma_done;
    m_start  = pop;
    m_retire = retire_n;
    m_busy   = busy_n;
    m_cnt    = cnt_n;
    m_irq    = irq_n;
    m_rvalid = cfg_req;
    m_rdata  = rd ? rv : 0;
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    chk("gnt", cfg_gnt, cfg_req);
    chk("start", dma_start, m_start);
    chk("src", dma_src, m_asrc);
    chk("dst", dma_dst, m_adst);
    chk("len", dma_len, m_alen);
    chk("irq", irq, m_irq);
    chk("rvalid", cfg_rvalid, m_rvalid);
    if (m_rvalid) chk("rdata", cfg_rdata, m_rdata);
  end

  // ---------------- stimulus helpers ----------------
  task automatic cfg_write(input logic [2:0] idx, input logic [31:0] data);
    @(negedge clk);
    cfg_req = 1; cfg_we = 1; cfg_addr = {27'b0, idx, 2'b0}; cfg_wdata = data;
    @(negedge clk);
    cfg_req = 0; cfg_we = 0;
  endtask

  task automatic cfg_read(input logic [2:0] idx, output logic [31:0] data);
    @(negedge clk);
    cfg_req = 1; cfg_we = 0; cfg_addr = {27'b0, idx, 2'b0};
    @(negedge clk);
    cfg_req = 0;
    chk("rd_rvalid", cfg_rvalid, 1);
    data = cfg_rdata;
  endtask

  task automatic push_desc(input logic [31:0] s, input logic [31:0] d, input logic [7:0] l);
    cfg_write(3'd0, s);
    cfg_write(3'd1, d);
    cfg_write(3'd2, {24'b0, l});
    cfg_write(3'd3, 32'h0);
  endtask

  task automatic wait_start(input string name);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dma_start) begin
        chk(name, 1, 1);
        return;
      end
    end
    chk(name, 0, 1);
  endtask

  task automatic pulse_done(input int gap);
    repeat (gap) @(negedge clk);
    dma_done = 1;
    repeat (2) @(negedge clk);
    dma_done = 0;
  endtask

  task automatic count_starts(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (dma_start) n++;
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] tmp;
    logic [2:0]  ridx;
    int          n;
    int          r;
    rst = 1; cfg_req = 0; cfg_we = 0; cfg_addr = 0; cfg_wdata = 0; dma_done = 0;
    repeat (3) @(negedge clk);
    chk("reset_start", dma_start, 0);
    chk("reset_irq", irq, 0);
    rst = 0;

    // single transfer with irq
    cfg_write(3'd6, 32'h3);
    push_desc(32'h1000, 32'h2000, 8'd8);
    wait_start("t1_start_seen");
    chk("t1_src", dma_src, 32'h1000);
    chk("t1_dst", dma_dst, 32'h2000);
    chk("t1_len", dma_len, 8);
    pulse_done(20);
    @(negedge clk);
    chk("t1_irq", irq, 1);
    cfg_read(3'd5, d); chk("t1_done_cnt", d, 1);
    cfg_read(3'd4, d); chk("t1_busy", d[0], 0);

    // fill, overflow, then drain in order
    cfg_write(3'd5, 0);
    cfg_write(3'd6, 0);
    for (int k = 0; k < 5; k++) push_desc(32'h100 * (k + 1), 32'h8000 + k, 8'(k + 1));
    cfg_read(3'd4, d); chk("t2_status_full_ovf", d, 32'h0000_040A);
    cfg_write(3'd6, 1);
    for (int k = 0; k < 4; k++) begin
      wait_start("t2_start_seen");
      chk("t2_src_order", dma_src, 32'h100 * (k + 1));
      chk("t2_len_order", dma_len, 32'(k + 1));
      pulse_done(3);
    end
    repeat (4) @(negedge clk);
    cfg_read(3'd5, d); chk("t2_done_cnt", d, 4);

    // zero length push
    cfg_write(3'd5, 0);
    cfg_write(3'd2, 0);
    cfg_write(3'd3, 0);
    cfg_read(3'd4, d); chk("t3_status_len_err", d, 32'h0000_0014);
    count_starts(10, n); chk("t3_no_start", n, 0);

    // stale done level across launches
    cfg_write(3'd5, 0);
    cfg_write(3'd6, 0);
    push_desc(32'h4000, 32'h5000, 8'd3);
    push_desc(32'h4100, 32'h5100, 8'd4);
    cfg_write(3'd6, 1);
    wait_start("t4_first_start");
    chk("t4_first_src", dma_src, 32'h4000);
    repeat (3) @(negedge clk);
    dma_done = 1;
    wait_start("t4_second_start");
    chk("t4_second_src", dma_src, 32'h4100);
    repeat (10) @(negedge clk);
    cfg_read(3'd4, d); chk("t4_still_busy", d, 32'h0000_0005);
    cfg_read(3'd5, d); chk("t4_cnt_held", d, 1);
    dma_done = 0;
    @(negedge clk);
    dma_done = 1;
    repeat (4) @(negedge clk);
    dma_done = 0;
    repeat (2) @(negedge clk);
    cfg_read(3'd5, d); chk("t4_cnt_after_edge", d, 2);
    cfg_read(3'd4, d); chk("t4_idle", d, 32'h0000_0004);

    // flush while first of three is running
    cfg_write(3'd5, 0);
    cfg_write(3'd6, 0);
    for (int k = 0; k < 3; k++) push_desc(32'h6000 + 32'(k), 32'h6100, 8'd2);
    cfg_write(3'd6, 1);
    wait_start("t5_start");
    chk("t5_src", dma_src, 32'h6000);
    @(negedge clk);
    cfg_write(3'd6, 32'h5);
    cfg_read(3'd4, d); chk("t5_flushed", d, 32'h0000_0005);
    pulse_done(1);
    repeat (3) @(negedge clk);
    cfg_read(3'd5, d); chk("t5_done_cnt", d, 1);
    count_starts(20, n); chk("t5_no_more_starts", n, 0);
    cfg_read(3'd4, d); chk("t5_idle_empty", d, 32'h0000_0004);

    // DONE_CNT write collides with retire
    cfg_write(3'd6, 3);
    push_desc(32'h7000, 32'h7100, 8'd5);
    wait_start("t6_start");
    @(negedge clk);
    dma_done = 1;
    @(negedge clk);
    cfg_req = 1; cfg_we = 1; cfg_addr = {27'b0, 3'd5, 2'b0}; cfg_wdata = 0;
    @(negedge clk);
    cfg_req = 0; cfg_we = 0; dma_done = 0;
    @(negedge clk);
    chk("t6_irq_set_wins", irq, 1);
    cfg_read(3'd5, d); chk("t6_cnt_set_wins", d, 1);

    // reset mid-transfer
    push_desc(32'h8000, 32'h8100, 8'd6);
    wait_start("t7_start");
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("t7_rst_src", dma_src, 0);
    chk("t7_rst_dst", dma_dst, 0);
    chk("t7_rst_len", dma_len, 0);
    chk("t7_rst_irq", irq, 0);
    chk("t7_rst_start", dma_start, 0);
    chk("t7_rst_rvalid", cfg_rvalid, 0);
    rst = 0;
    cfg_read(3'd4, d); chk("t7_status", d, 32'h0000_0004);
    cfg_read(3'd6, d); chk("t7_ctrl", d, 0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = (c >= 1500 && c < 1502);
      if ($urandom_range(0, 5) == 0) dma_done = !dma_done;
      tmp = $urandom;
      r = $urandom_range(0, 15);
      cfg_req = ($urandom_range(0, 2) == 0);
      cfg_we  = $urandom_range(0, 1);
      cfg_wdata = $urandom;
      if (r < 2)       ridx = 3'd0;
      else if (r < 4)  ridx = 3'd1;
      else if (r < 6)  ridx = 3'd2;
      else if (r < 9)  ridx = 3'd3;
      else if (r < 11) ridx = 3'd4;
      else if (r < 12) ridx = 3'd5;
      else if (r < 14) ridx = 3'd6;
      else if (r < 15) ridx = 3'd7;
      else             ridx = 3'($urandom_range(0, 7));
      if (ridx == 3'd2)
        cfg_wdata[7:0] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      if (ridx == 3'd5) cfg_we = ($urandom_range(0, 3) == 0);
      if (ridx == 3'd6) begin
        cfg_wdata[0] = ($urandom_range(0, 9) != 0);
        cfg_wdata[2] = ($urandom_range(0, 9) == 0);
      end
      cfg_addr = {tmp[31:5], ridx, tmp[1:0]};
    end
    @(negedge clk);
    cfg_req = 0; cfg_we = 0; rst = 0; dma_done = 0;
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
